// File: rtl/bsg_fifo_tracker_multi.sv
// Occupancy and pointer tracker for a multi-word ring buffer: all-or-nothing
// acceptance of enqueue/dequeue word counts against registered occupancy.

module bsg_circular_ptr #(
    parameter int unsigned slots_p   = 32,
    parameter int unsigned max_add_p = 5
) (
    input  logic                               clk,
    input  logic                               reset_i,
    input  logic [$clog2(max_add_p+1)-1:0]     add_i,
    output logic [$clog2(slots_p)-1:0]         o,
    output logic [$clog2(slots_p)-1:0]         n_o
);
    localparam int unsigned ptr_w = $clog2(slots_p);

    logic [ptr_w-1:0] ptr_q;
    logic [ptr_w-1:0] ptr_d;

    // Wraps modulo slots_p through natural overflow of the ptr_w-bit sum.
    always_comb begin
        ptr_d = ptr_q + ptr_w'(add_i);
    end

    always_ff @(posedge clk) begin
        if (reset_i) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end

    assign o   = ptr_q;
    assign n_o = ptr_d;
endmodule

module bsg_fifo_tracker_multi #(
    parameter int unsigned slots_p   = 32,
    parameter int unsigned max_add_p = 5
) (
    input  logic                               clk,
    input  logic                               reset_i,
    input  logic [$clog2(max_add_p+1)-1:0]     enq_cnt_i,
    input  logic [$clog2(max_add_p+1)-1:0]     deq_cnt_i,
    output logic                               enq_yumi_o,
    output logic                               deq_yumi_o,
    output logic [$clog2(max_add_p+1)-1:0]     wr_add_o,
    output logic [$clog2(max_add_p+1)-1:0]     rd_add_o,
    output logic [$clog2(slots_p)-1:0]         wptr_r_o,
    output logic [$clog2(slots_p)-1:0]         rptr_r_o,
    output logic [$clog2(slots_p)-1:0]         wptr_n_o,
    output logic [$clog2(slots_p+1)-1:0]       count_r_o,
    output logic [$clog2(slots_p+1)-1:0]       free_r_o,
    output logic                               empty_o,
    output logic                               full_o,
    output logic                               err_o
);
    localparam int unsigned ptr_w = $clog2(slots_p);
    localparam int unsigned cnt_w = $clog2(slots_p + 1);
    localparam int unsigned add_w = $clog2(max_add_p + 1);
    localparam int unsigned sum_w = cnt_w + 1;

    logic [cnt_w-1:0] count_q, count_d;
    logic [cnt_w-1:0] free_q,  free_d;
    logic             err_q,   err_d;

    logic             enq_legal, deq_legal;
    logic             enq_yumi,  deq_yumi;
    logic [sum_w-1:0] count_sum;
    logic [ptr_w-1:0] rptr_n;

    // Acceptance looks only at registered occupancy; enq and deq never see each other.
    always_comb begin
        enq_legal  = (enq_cnt_i <= add_w'(max_add_p));
        deq_legal  = (deq_cnt_i <= add_w'(max_add_p));
        enq_yumi   = !reset_i && (enq_cnt_i != '0) && enq_legal
                     && (cnt_w'(enq_cnt_i) <= free_q);
        deq_yumi   = !reset_i && (deq_cnt_i != '0) && deq_legal
                     && (cnt_w'(deq_cnt_i) <= count_q);
        wr_add_o   = enq_yumi ? enq_cnt_i : '0;
        rd_add_o   = deq_yumi ? deq_cnt_i : '0;
        enq_yumi_o = enq_yumi;
        deq_yumi_o = deq_yumi;

        count_sum  = sum_w'(count_q) + sum_w'(wr_add_o) - sum_w'(rd_add_o);
        count_d    = cnt_w'(count_sum);
        free_d     = cnt_w'(slots_p) - count_d;
        err_d      = err_q || !enq_legal || !deq_legal
                     || ((deq_cnt_i != '0) && (cnt_w'(deq_cnt_i) > count_q));
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            count_q <= '0;
            free_q  <= cnt_w'(slots_p);
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            free_q  <= free_d;
            err_q   <= err_d;
        end
    end

    bsg_circular_ptr #(.slots_p(slots_p), .max_add_p(max_add_p)) wr_ptr (
        .clk     (clk),
        .reset_i (reset_i),
        .add_i   (wr_add_o),
        .o       (wptr_r_o),
        .n_o     (wptr_n_o)
    );

    bsg_circular_ptr #(.slots_p(slots_p), .max_add_p(max_add_p)) rd_ptr (
        .clk     (clk),
        .reset_i (reset_i),
        .add_i   (rd_add_o),
        .o       (rptr_r_o),
        .n_o     (rptr_n)
    );

    // Pointer distance must track occupancy modulo the ring depth.
    ptr_count_consistent_a: assert property (@(posedge clk) disable iff (reset_i)
        ptr_w'(wptr_n_o - rptr_n) == ptr_w'(count_d));

    assign count_r_o = count_q;
    assign free_r_o  = free_q;
    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == cnt_w'(slots_p));
    assign err_o     = err_q;
endmodule

// File: tb/tb_bsg_fifo_tracker_multi.sv
// Directed and randomized checks of bsg_fifo_tracker_multi against a
// word-count reference model (total words written/read since reset).

module tb_bsg_fifo_tracker_multi;
    localparam int SLOTS = 32;
    localparam int MAXA  = 5;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic [2:0] enq_cnt_i = '0;
    logic [2:0] deq_cnt_i = '0;
    logic       enq_yumi_o, deq_yumi_o;
    logic [2:0] wr_add_o, rd_add_o;
    logic [4:0] wptr_r_o, rptr_r_o, wptr_n_o;
    logic [5:0] count_r_o, free_r_o;
    logic       empty_o, full_o, err_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: totals since reset; pointers and occupancy follow from them.
    int  m_wr  = 0;
    int  m_rd  = 0;
    bit  m_err = 1'b0;

    bsg_fifo_tracker_multi dut (
        .clk       (clk),
        .reset_i   (reset_i),
        .enq_cnt_i (enq_cnt_i),
        .deq_cnt_i (deq_cnt_i),
        .enq_yumi_o(enq_yumi_o),
        .deq_yumi_o(deq_yumi_o),
        .wr_add_o  (wr_add_o),
        .rd_add_o  (rd_add_o),
        .wptr_r_o  (wptr_r_o),
        .rptr_r_o  (rptr_r_o),
        .wptr_n_o  (wptr_n_o),
        .count_r_o (count_r_o),
        .free_r_o  (free_r_o),
        .empty_o   (empty_o),
        .full_o    (full_o),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_state();
        int cnt;
        cnt = m_wr - m_rd;
        check_eq("wptr_r", int'(wptr_r_o), m_wr % SLOTS);
        check_eq("rptr_r", int'(rptr_r_o), m_rd % SLOTS);
        check_eq("count_r", int'(count_r_o), cnt);
        check_eq("free_r", int'(free_r_o), SLOTS - cnt);
        check_eq("empty", int'(empty_o), (cnt == 0) ? 1 : 0);
        check_eq("full", int'(full_o), (cnt == SLOTS) ? 1 : 0);
        check_eq("err", int'(err_o), m_err ? 1 : 0);
    endtask

    // One cycle: apply inputs, check zero-latency outputs, clock, check registered state.
    task automatic step(input int enq, input int deq, input bit rst);
        int  cnt;
        bit  e_ok, d_ok;
        cnt = m_wr - m_rd;
        reset_i   = rst;
        enq_cnt_i = 3'(enq);
        deq_cnt_i = 3'(deq);
        #1;
        e_ok = !rst && enq != 0 && enq <= MAXA && enq <= SLOTS - cnt;
        d_ok = !rst && deq != 0 && deq <= MAXA && deq <= cnt;
        check_eq("enq_yumi", int'(enq_yumi_o), e_ok ? 1 : 0);
        check_eq("deq_yumi", int'(deq_yumi_o), d_ok ? 1 : 0);
        check_eq("wr_add", int'(wr_add_o), e_ok ? enq : 0);
        check_eq("rd_add", int'(rd_add_o), d_ok ? deq : 0);
        if (!rst)
            check_eq("wptr_n", int'(wptr_n_o), (m_wr + (e_ok ? enq : 0)) % SLOTS);
        if (rst) begin
            m_wr = 0; m_rd = 0; m_err = 1'b0;
        end else begin
            if (enq > MAXA || deq > MAXA || (deq != 0 && deq > cnt)) m_err = 1'b1;
            if (e_ok) m_wr += enq;
            if (d_ok) m_rd += deq;
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    initial begin
        int e, d;
        bit r;
        // Reset and idle
        step(0, 0, 1);
        step(0, 0, 1);
        repeat (3) step(0, 0, 0);

        // Fill to 30, reject 3 with 2 free, then fill and wrap the write pointer
        repeat (6) step(5, 0, 0);
        step(3, 0, 0);
        step(2, 0, 0);
        check_eq("full_after_fill", int'(full_o), 1);
        step(1, 0, 0);

        // Read pointer wrap: reach rptr=30 with count 5, then pop 4
        repeat (6) step(0, 5, 0);
        step(3, 0, 0);
        check_eq("rptr_pre_wrap", int'(rptr_r_o), 30);
        step(0, 4, 0);
        check_eq("rptr_wrapped", int'(rptr_r_o), 2);

        // Simultaneous enq/deq at count 30: enq rejected, deq accepted
        step(0, 0, 1);
        repeat (6) step(5, 0, 0);
        step(5, 5, 0);
        check_eq("count_after_sim", int'(count_r_o), 25);
        step(5, 0, 0);

        // Underflow request and oversize enqueue raise the sticky error
        repeat (5) step(0, 5, 0);
        repeat (4) step(0, 1, 0);
        step(0, 3, 0);
        check_eq("err_underflow", int'(err_o), 1);
        step(7, 0, 0);
        repeat (2) step(1, 1, 0);

        // Reset while count=17 with both requests active
        step(0, 0, 1);
        repeat (3) step(5, 0, 0);
        step(2, 0, 0);
        step(4, 3, 1);
        step(0, 0, 0);

        // Randomized traffic with occasional illegal counts and resets
        for (int i = 0; i < 3000; i++) begin
            e = ($urandom % 20 == 0) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5));
            d = ($urandom % 20 == 0) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5));
            r = ($urandom % 100 == 0);
            step(e, d, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
